// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the C17 BIST controller: FSM states, LFSR/MISR
// taps, pattern bit positions and the reference C17 function.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // x^5 + x^3 + 1: feedback is q[4] ^ q[2]
  localparam int unsigned LFSR_TAP_HI = 4;
  localparam int unsigned LFSR_TAP_LO = 2;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam int unsigned PAT_1GAT = 0;
  localparam int unsigned PAT_2GAT = 1;
  localparam int unsigned PAT_3GAT = 2;
  localparam int unsigned PAT_6GAT = 3;
  localparam int unsigned PAT_7GAT = 4;

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    return {q[3:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

  // Returns {23GAT, 22GAT}
  function automatic logic [1:0] c17_golden(input logic [4:0] pat);
    logic n6;
    logic n7;
    logic n8;
    n6 = pat[PAT_1GAT] & pat[PAT_3GAT];
    n7 = pat[PAT_3GAT] & pat[PAT_6GAT];
    n8 = pat[PAT_2GAT] & ~n7;
    return {n8 | (pat[PAT_7GAT] & ~n7), n6 | n8};
  endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// 16-bit multiple-input signature register with synchronous load, enable and a
// 2-bit parallel input folded into bits [1:0].
module c17_bist_misr
  import c17_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [1:0]  data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15]}} & MISR_POLY) ^ {14'b0, data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the C17 netlist: LFSR pattern source, latency-matched MISR capture.
// Define C17_BIST_GOLDEN_EN to compile in the golden-model compare and mismatch counter.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 32,
  parameter logic [4:0]  LFSR_SEED   = 5'h01,
  parameter logic [15:0] MISR_SEED   = 16'hFFFF,
  parameter int unsigned RESP_LAT    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  pattern,
  output logic        pattern_valid,
  input  logic [1:0]  response,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [7:0]  mismatch_cnt
);

  localparam int unsigned CNT_W = (NUM_VECTORS < 1) ? 1 : $clog2(NUM_VECTORS + 1);
  localparam logic [4:0] SEED_N = (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((NUM_VECTORS == 0) ? 0 : NUM_VECTORS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'((RESP_LAT == 0) ? 0 : RESP_LAT - 1);

  state_e           state_q, state_d;
  logic [4:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             pv_q, pv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             launch;
  logic             cap_vld;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch = 1'b1;
          lfsr_d = SEED_N;
          cnt_d  = '0;
          dcnt_d = '0;
          if (NUM_VECTORS != 0)   state_d = ST_RUN;
          else if (RESP_LAT != 0) state_d = ST_DRAIN;
          else                    state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // The last pattern stays on the bus while the pipeline drains.
        if (cnt_q == CNT_LAST) begin
          state_d = (RESP_LAT != 0) ? ST_DRAIN : ST_DONE;
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      ST_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DRAIN_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    pv_d   = (state_d == ST_RUN);
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_N;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef C17_BIST_GOLDEN_EN
  logic [1:0] gold_cap;
`endif

  // Valid (and golden value) travel RESP_LAT cycles to line up with the netlist response.
  generate
    if (RESP_LAT == 0) begin : g_lat0
      assign cap_vld = pv_q;
`ifdef C17_BIST_GOLDEN_EN
      assign gold_cap = c17_golden(lfsr_q);
`endif
    end else begin : g_latn
      logic [RESP_LAT-1:0] vld_sr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr_q <= '0;
        end else begin
          vld_sr_q[0] <= pv_q;
          for (int unsigned i = 1; i < RESP_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
        end
      end
      assign cap_vld = vld_sr_q[RESP_LAT-1];
`ifdef C17_BIST_GOLDEN_EN
      logic [1:0] gold_sr_q [RESP_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < RESP_LAT; i++) gold_sr_q[i] <= '0;
        end else begin
          gold_sr_q[0] <= c17_golden(lfsr_q);
          for (int unsigned i = 1; i < RESP_LAT; i++) gold_sr_q[i] <= gold_sr_q[i-1];
        end
      end
      assign gold_cap = gold_sr_q[RESP_LAT-1];
`endif
    end
  endgenerate

  c17_bist_misr #(
    .SEED (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (launch),
    .en_i   (cap_vld),
    .data_i (response),
    .sig_o  (signature)
  );

`ifdef C17_BIST_GOLDEN_EN
  logic [7:0] mm_q, mm_d;

  always_comb begin
    mm_d = mm_q;
    if (launch) begin
      mm_d = '0;
    end else if (cap_vld && (gold_cap != response) && (mm_q != 8'hFF)) begin
      mm_d = mm_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_q <= '0;
    end else begin
      mm_q <= mm_d;
    end
  end

  assign mismatch_cnt = mm_q;
`else
  assign mismatch_cnt = '0;
`endif

  assign pattern       = lfsr_q;
  assign pattern_valid = pv_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench for c17_bist_ctrl: six instances cover the vector-count, latency,
// seed-normalisation and faulty-netlist cases; one monitor does all comparisons.
module tb_c17_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] start_w;
  logic [4:0] pat_w  [6];
  logic [1:0] resp_w [6];
  logic [15:0] sig_w [6];
  logic [7:0] mm_w   [6];
  logic [5:0] pv_w;
  logic [5:0] busy_w;
  logic [5:0] done_w;
  logic [5:0] done_prev;
  int         cyc;
  int         n_chk;
  int         n_pass;

  typedef struct {
    int          id;
    logic [15:0] sig;
    logic [7:0]  mm;
    int          cyc;
  } done_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  done_t      done_q[$];
  logic [4:0] pat_q[$];
  dchk_t      dq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] c17m(input logic [4:0] p);
    logic g1, g2, g3, g6, g7, n6, n7, n8;
    g1 = p[0]; g2 = p[1]; g3 = p[2]; g6 = p[3]; g7 = p[4];
    n6 = g1 & g3;
    n7 = g3 & g6;
    n8 = g2 & ~n7;
    return {n8 | (g7 & ~n7), n6 | n8};
  endfunction

  // Signature of a run, independent of response latency.
  function automatic logic [15:0] sig_model(input int nv, input bit fault);
    logic [4:0]  p;
    logic [15:0] s;
    logic [15:0] n;
    logic [1:0]  r;
    p = 5'h01;
    s = 16'hFFFF;
    for (int i = 0; i < nv; i++) begin
      r = c17m(p) ^ {1'b0, fault};
      n = {s[14:0], 1'b0};
      n[0]  = s[15] ^ r[0];
      n[1]  = s[0] ^ r[1];
      n[5]  = s[4] ^ s[15];
      n[12] = s[11] ^ s[15];
      s = n;
      p = {p[3:0], p[4] ^ p[2]};
    end
    return s;
  endfunction

  function automatic logic [7:0] mm_model(input int nv, input bit fault);
`ifdef C17_BIST_GOLDEN_EN
    if (!fault) return 8'd0;
    return (nv > 255) ? 8'd255 : 8'(nv);
`else
    return 8'd0;
`endif
  endfunction

  // Netlist models: combinational, two-stage latency, and bit0-inverted faults.
  logic [1:0] lat1 = 2'b00;
  logic [1:0] lat2 = 2'b00;
  always @(posedge clk) begin
    lat1 <= c17m(pat_w[2]);
    lat2 <= lat1;
  end
  assign resp_w[0] = c17m(pat_w[0]);
  assign resp_w[1] = c17m(pat_w[1]);
  assign resp_w[2] = lat2;
  assign resp_w[3] = c17m(pat_w[3]);
  assign resp_w[4] = c17m(pat_w[4]) ^ 2'b01;
  assign resp_w[5] = c17m(pat_w[5]) ^ 2'b01;

  c17_bist_ctrl #(.NUM_VECTORS(32), .RESP_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .pattern(pat_w[0]), .pattern_valid(pv_w[0]),
    .response(resp_w[0]), .busy(busy_w[0]), .done(done_w[0]), .signature(sig_w[0]), .mismatch_cnt(mm_w[0]));
  c17_bist_ctrl #(.NUM_VECTORS(31), .LFSR_SEED(5'h00), .RESP_LAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .pattern(pat_w[1]), .pattern_valid(pv_w[1]),
    .response(resp_w[1]), .busy(busy_w[1]), .done(done_w[1]), .signature(sig_w[1]), .mismatch_cnt(mm_w[1]));
  c17_bist_ctrl #(.NUM_VECTORS(4), .RESP_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .pattern(pat_w[2]), .pattern_valid(pv_w[2]),
    .response(resp_w[2]), .busy(busy_w[2]), .done(done_w[2]), .signature(sig_w[2]), .mismatch_cnt(mm_w[2]));
  c17_bist_ctrl #(.NUM_VECTORS(0), .RESP_LAT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_w[3]), .pattern(pat_w[3]), .pattern_valid(pv_w[3]),
    .response(resp_w[3]), .busy(busy_w[3]), .done(done_w[3]), .signature(sig_w[3]), .mismatch_cnt(mm_w[3]));
  c17_bist_ctrl #(.NUM_VECTORS(20), .RESP_LAT(0)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_w[4]), .pattern(pat_w[4]), .pattern_valid(pv_w[4]),
    .response(resp_w[4]), .busy(busy_w[4]), .done(done_w[4]), .signature(sig_w[4]), .mismatch_cnt(mm_w[4]));
  c17_bist_ctrl #(.NUM_VECTORS(300), .RESP_LAT(0)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start_w[5]), .pattern(pat_w[5]), .pattern_valid(pv_w[5]),
    .response(resp_w[5]), .busy(busy_w[5]), .done(done_w[5]), .signature(sig_w[5]), .mismatch_cnt(mm_w[5]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    dchk_t d;
    done_t r;
    n_chk = 0;
    n_pass = 0;
    done_prev = '0;
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        chk(d.name, d.act, d.exp);
      end
      if (pv_w[0] && pat_q.size() > 0) chk("lfsr_seq", int'(pat_w[0]), int'(pat_q.pop_front()));
      for (int i = 0; i < 6; i++) begin
        if (done_w[i] && !done_prev[i]) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", i, -1);
          end else begin
            r = done_q.pop_front();
            chk("done_id", i, r.id);
            chk("done_cycle", cyc, r.cyc);
            chk("signature", int'(sig_w[i]), int'(r.sig));
            chk("mismatch_cnt", int'(mm_w[i]), int'(r.mm));
          end
        end
      end
      done_prev = done_w;
    end
  end

  task automatic push_chk(input string nm, input int act, input int exp);
    dchk_t d;
    d.name = nm;
    d.act  = act;
    d.exp  = exp;
    dq.push_back(d);
  endtask

  task automatic issue(input int id, input int nv, input int lat, input logic [15:0] sig,
                       input logic [7:0] mm);
    done_t r;
    @(negedge clk);
    r.id  = id;
    r.sig = sig;
    r.mm  = mm;
    r.cyc = cyc + nv + lat + 1;
    done_q.push_back(r);
    start_w[id] = 1'b1;
    @(negedge clk);
    start_w[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int bound);
    int n;
    n = 0;
    while (!done_w[id] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done_w[id]) push_chk("done_timeout", 0, 1);
  endtask

  task automatic push_reset_u0();
    push_chk("rst_pattern", int'(pat_w[0]), 1);
    push_chk("rst_pattern_valid", int'(pv_w[0]), 0);
    push_chk("rst_busy", int'(busy_w[0]), 0);
    push_chk("rst_done", int'(done_w[0]), 0);
    push_chk("rst_signature", int'(sig_w[0]), 'hFFFF);
    push_chk("rst_mismatch_cnt", int'(mm_w[0]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  exp_seq [6];
    logic [31:0] seen;
    int          nvalid;

    exp_seq = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
    cyc = 0;
    rst_n = 1'b0;
    start_w = '0;
    repeat (3) @(negedge clk);
    push_reset_u0();
    push_chk("rst_seed_norm", int'(pat_w[1]), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Run 1 of u0: first six patterns, busy/valid in RUN, signature and latency at done.
    for (int i = 0; i < 6; i++) pat_q.push_back(exp_seq[i]);
    issue(0, 32, 0, sig_model(32, 1'b0), mm_model(32, 1'b0));
    repeat (3) @(negedge clk);
    push_chk("run_busy", int'(busy_w[0]), 1);
    push_chk("run_pattern_valid", int'(pv_w[0]), 1);
    wait_done(0, 40);
    push_chk("done_busy", int'(busy_w[0]), 0);
    push_chk("done_pattern_valid", int'(pv_w[0]), 0);

    // Restart from DONE with a stray start mid-run: same signature, unchanged timing.
    issue(0, 32, 0, sig_model(32, 1'b0), mm_model(32, 1'b0));
    repeat (4) @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    push_chk("ignored_start_busy", int'(busy_w[0]), 1);
    wait_done(0, 40);

    // u1: zero seed normalised, 31 distinct nonzero patterns.
    issue(1, 31, 0, sig_model(31, 1'b0), mm_model(31, 1'b0));
    seen = '0;
    nvalid = 0;
    for (int i = 0; i < 31; i++) begin
      if (pv_w[1]) begin
        nvalid++;
        seen[pat_w[1]] = 1'b1;
      end
      @(negedge clk);
    end
    push_chk("lfsr_distinct", $countones(seen), 31);
    push_chk("lfsr_no_zero", int'(seen[0]), 0);
    push_chk("lfsr_valid_cycles", nvalid, 31);
    wait_done(1, 10);

    // u2: RESP_LAT=2, done 7 cycles after the start edge, latency-free signature.
    issue(2, 4, 2, sig_model(4, 1'b0), mm_model(4, 1'b0));
    wait_done(2, 15);

    // u3: zero vectors.
    issue(3, 0, 0, 16'hFFFF, 8'd0);
    wait_done(3, 5);

    // u4/u5: faulty netlist, mismatch count and saturation.
    issue(4, 20, 0, sig_model(20, 1'b1), mm_model(20, 1'b1));
    wait_done(4, 30);
    issue(5, 300, 0, sig_model(300, 1'b1), mm_model(300, 1'b1));
    wait_done(5, 310);

    // Reset asserted mid-run on u0: immediate return to reset values.
    @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (10) @(negedge clk);
    push_chk("midrun_busy", int'(busy_w[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    push_reset_u0();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push_chk("scoreboard_empty", done_q.size() + pat_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
